// File: rtl/mem_sram_adapter.sv
// Request/ack memory front-end for a single-port synchronous SRAM macro.
// Runs an optional post-reset fill of the whole array and filters out-of-range
// word addresses before they reach the macro.
module mem_sram_adapter #(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH_LOG2 = 10,
    parameter int unsigned           RD_LATENCY = 1,
    parameter bit                    INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_rst,
    input  logic                  mem_req_vld,
    output logic                  mem_ack_vld,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_wr_en,
    input  logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [DEPTH_LOG2-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  init_done,
    output logic                  err_oor
);

    typedef enum logic [1:0] {StInit, StIdle, StRdWait, StAck} state_e;

    localparam state_e          ResetState = INIT_EN ? StInit : StIdle;
    localparam logic [1:0]      LatLoad    = 2'(RD_LATENCY - 1);
    localparam logic [DEPTH_LOG2-1:0] IdxOne = DEPTH_LOG2'(1);

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [1:0]            lat_q, lat_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  init_done_q, init_done_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  cs, we;
    logic                  req_go;
    logic                  addr_oor;

    assign req_go   = mem_req_vld & (mem_wr_en | mem_rd_en);
    assign addr_oor = |mem_addr[ADDR_WIDTH-1:DEPTH_LOG2];

    // Next-state, SRAM strobes and response data for the current cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        init_done_d = init_done_q;
        rd_data_d   = rd_data_q;
        cs          = 1'b0;
        we          = 1'b0;
        sram_addr   = mem_addr[DEPTH_LOG2-1:0];
        sram_wdata  = mem_wr_data;

        if (soft_rst) begin
            // Restart the fill, or drop whatever access is in flight.
            if (state_q == StInit) begin
                idx_d = '0;
            end else begin
                state_d = StIdle;
            end
        end else begin
            case (state_q)
                StInit: begin
                    cs         = 1'b1;
                    we         = 1'b1;
                    sram_addr  = idx_q;
                    sram_wdata = INIT_VALUE;
                    if (&idx_q) begin
                        idx_d       = '0;
                        state_d     = StIdle;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxOne;
                    end
                end
                StIdle: begin
                    if (req_go) begin
                        if (addr_oor) begin
                            // Never touches the macro; a read answers with zero.
                            state_d = StAck;
                            ack_d   = 1'b1;
                            err_d   = 1'b1;
                            if (!mem_wr_en) begin
                                rd_data_d = '0;
                            end
                        end else if (mem_wr_en) begin
                            cs      = 1'b1;
                            we      = 1'b1;
                            state_d = StAck;
                            ack_d   = 1'b1;
                        end else begin
                            cs      = 1'b1;
                            state_d = StRdWait;
                            lat_d   = LatLoad;
                        end
                    end
                end
                StRdWait: begin
                    if (lat_q == 2'd0) begin
                        rd_data_d = sram_rdata;
                        state_d   = StAck;
                        ack_d     = 1'b1;
                    end else begin
                        lat_d = lat_q - 2'd1;
                    end
                end
                StAck: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ResetState;
            idx_q       <= '0;
            lat_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            init_done_q <= !INIT_EN;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            init_done_q <= init_done_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Reset state is StInit, so strobes are gated to keep the macro idle while rst_n is low.
    assign sram_cs     = cs & rst_n;
    assign sram_we     = we & rst_n;
    assign mem_ack_vld = ack_q & ~soft_rst;
    assign err_oor     = err_q & ~soft_rst;
    assign mem_rd_data = rd_data_q;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_mem_sram_adapter.sv
// Directed bench for mem_sram_adapter with a behavioural 16-word, 2-cycle SRAM.
module tb_mem_sram_adapter;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned DL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          soft_rst = 1'b0;
    logic          mem_req_vld = 1'b0;
    logic          mem_ack_vld;
    logic [AW-1:0] mem_addr = '0;
    logic          mem_wr_en = 1'b0;
    logic          mem_rd_en = 1'b0;
    logic [DW-1:0] mem_wr_data = '0;
    logic [DW-1:0] mem_rd_data;
    logic          sram_cs;
    logic          sram_we;
    logic [DL-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          init_done;
    logic          err_oor;

    mem_sram_adapter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH_LOG2 (DL),
        .RD_LATENCY (2),
        .INIT_EN    (1'b1),
        .INIT_VALUE (64'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_rst    (soft_rst),
        .mem_req_vld (mem_req_vld),
        .mem_ack_vld (mem_ack_vld),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .sram_cs     (sram_cs),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .init_done   (init_done),
        .err_oor     (err_oor)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro, read latency 2.
    logic [DW-1:0] sram_mem [16];
    logic [DW-1:0] rd_pipe0, rd_pipe1;
    initial begin
        for (int i = 0; i < 16; i++) sram_mem[i] = 64'hA5A5_5A5A_C3C3_3C3C ^ 64'(i);
    end
    always @(posedge clk) begin
        if (sram_cs && sram_we) sram_mem[sram_addr] <= sram_wdata;
        rd_pipe0 <= sram_mem[sram_addr];
        rd_pipe1 <= rd_pipe0;
    end
    assign sram_rdata = rd_pipe1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [DW-1:0] rd_data;
        logic          err;
        logic          is_rd;
        logic [3:0]    lat;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] last_rd = '0;
    int            n_cmp = 0;
    int            n_mis = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected response for a request; also tracks memory contents.
    task automatic push_exp(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd);
        exp_t e;
        logic oor;
        oor       = (addr[AW-1:DL] != '0);
        e.err     = oor;
        e.is_rd   = !wr;
        e.lat     = (oor || wr) ? 4'd1 : 4'd3;
        e.rd_data = oor ? '0 : ref_mem[addr[DL-1:0]];
        if (wr && !oor) ref_mem[addr[DL-1:0]] = wd;
        sb_q.push_back(e);
    endtask

    task automatic check_accept(input string tag, input logic [AW-1:0] addr, input logic wr,
                                input logic [DW-1:0] wd);
        if (addr[AW-1:DL] != '0) begin
            check({tag, "_no_cs"}, 64'(sram_cs), 64'd0);
        end else begin
            check({tag, "_cs_we"}, 64'({sram_cs, sram_we}), 64'({1'b1, wr}));
            check({tag, "_addr"}, 64'(sram_addr), 64'(addr[DL-1:0]));
            if (wr) check({tag, "_wdata"}, sram_wdata, wd);
        end
    endtask

    task automatic issue(input string tag, input logic [AW-1:0] addr, input logic wr,
                         input logic rd, input logic [DW-1:0] wd);
        @(negedge clk);
        mem_req_vld = 1'b1;
        mem_addr    = addr;
        mem_wr_en   = wr;
        mem_rd_en   = rd;
        mem_wr_data = wd;
        #1;
        check_accept(tag, addr, wr, wd);
        push_exp(addr, wr, wd);
    endtask

    // Request stays asserted while waiting, so any cs here means a spurious access.
    task automatic wait_ack(input string tag);
        int   n = 0;
        logic got = 1'b0;
        logic extra_cs = 1'b0;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            n++;
            if (sram_cs) extra_cs = 1'b1;
            if (mem_ack_vld) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_ack_seen"}, 64'(got), 64'd1);
        check({tag, "_no_extra_cs"}, 64'(extra_cs), 64'd0);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_latency"}, 64'(n), 64'(e.lat));
            if (got) begin
                check({tag, "_err"}, 64'(err_oor), 64'(e.err));
                if (e.is_rd) begin
                    check({tag, "_rdata"}, mem_rd_data, e.rd_data);
                    last_rd = e.rd_data;
                end
            end
        end
    endtask

    task automatic release_req(input string tag);
        @(negedge clk);
        mem_req_vld = 1'b0;
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        #1;
        check({tag, "_single_ack"}, 64'(mem_ack_vld), 64'd0);
    endtask

    initial begin
        int   cnt;
        logic flag;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        check("rst_ack", 64'(mem_ack_vld), 64'd0);
        check("rst_rdata", mem_rd_data, 64'd0);
        check("rst_cs_we", 64'({sram_cs, sram_we}), 64'd0);
        check("rst_err", 64'(err_oor), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);

        // Init sweep with a read of word 5 held pending throughout.
        @(negedge clk);
        rst_n       = 1'b1;
        mem_req_vld = 1'b1;
        mem_rd_en   = 1'b1;
        mem_addr    = 32'd5;
        cnt         = 0;
        flag        = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (init_done) break;
            check("init_word", 64'({sram_cs, sram_we, sram_addr}), 64'({1'b1, 1'b1, 4'(cnt)}));
            if (sram_wdata !== 64'd0 || mem_ack_vld) flag = 1'b1;
            cnt++;
            @(negedge clk);
        end
        check("init_cycles", 64'(cnt), 64'd16);
        check("init_wdata_no_ack", 64'(flag), 64'd0);
        check("init_done_high", 64'(init_done), 64'd1);
        check_accept("init_held_rd", 32'd5, 1'b0, '0);
        push_exp(32'd5, 1'b0, '0);
        wait_ack("init_held_rd");
        release_req("init_held_rd");

        // Write then read back.
        issue("wr3", 32'd3, 1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567);
        wait_ack("wr3");
        release_req("wr3");
        issue("rd3", 32'd3, 1'b0, 1'b1, '0);
        wait_ack("rd3");
        release_req("rd3");

        // Top in-range word.
        issue("wr15", 32'd15, 1'b1, 1'b0, 64'h1111_2222_3333_4444);
        wait_ack("wr15");
        release_req("wr15");
        issue("rd15", 32'd15, 1'b0, 1'b1, '0);
        wait_ack("rd15");
        release_req("rd15");

        // Out-of-range accesses; the write must not alias onto word 0.
        issue("oor_rd400", 32'h0000_0400, 1'b0, 1'b1, '0);
        wait_ack("oor_rd400");
        release_req("oor_rd400");
        issue("oor_wr10", 32'h0000_0010, 1'b1, 1'b0, 64'hFFFF_0000_FFFF_0000);
        wait_ack("oor_wr10");
        release_req("oor_wr10");
        issue("rd0", 32'd0, 1'b0, 1'b1, '0);
        wait_ack("rd0");
        release_req("rd0");

        // Valid with no enable is ignored.
        @(negedge clk);
        mem_req_vld = 1'b1;
        mem_addr    = 32'd3;
        flag        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (sram_cs || mem_ack_vld) flag = 1'b1;
            @(negedge clk);
        end
        mem_req_vld = 1'b0;
        check("no_enable_ignored", 64'(flag), 64'd0);

        // Both enables act as a write.
        issue("both_en", 32'd6, 1'b1, 1'b1, 64'h0BAD_F00D_CAFE_1234);
        wait_ack("both_en");
        release_req("both_en");
        issue("rd6", 32'd6, 1'b0, 1'b1, '0);
        wait_ack("rd6");
        release_req("rd6");

        // Request held across the ack: next access only in the cycle after.
        issue("held_a", 32'd3, 1'b0, 1'b1, '0);
        wait_ack("held_a");
        issue("held_b", 32'd3, 1'b0, 1'b1, '0);
        wait_ack("held_b");
        release_req("held_b");

        // soft_rst during read wait drops the read.
        issue("srst_rd", 32'd15, 1'b0, 1'b1, '0);
        @(negedge clk);
        mem_req_vld = 1'b0;
        mem_rd_en   = 1'b0;
        soft_rst    = 1'b1;
        #1;
        check("srst_ack_low", 64'(mem_ack_vld), 64'd0);
        @(negedge clk);
        soft_rst = 1'b0;
        #1;
        check("srst_cs_low", 64'(sram_cs), 64'd0);
        check("srst_rdata_kept", mem_rd_data, last_rd);
        void'(sb_q.pop_back());
        flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (mem_ack_vld) flag = 1'b1;
        end
        check("srst_no_ack", 64'(flag), 64'd0);
        check("srst_rdata_still", mem_rd_data, last_rd);
        issue("srst_wr", 32'd9, 1'b1, 1'b0, 64'h9999_8888_7777_6666);
        wait_ack("srst_wr");
        release_req("srst_wr");
        check("wr_keeps_rdata", mem_rd_data, last_rd);

        // Hard reset mid-transaction, then re-init clears memory.
        issue("rst_mid_wr", 32'd9, 1'b1, 1'b0, 64'h5555_AAAA_5555_AAAA);
        @(negedge clk);
        rst_n       = 1'b0;
        mem_req_vld = 1'b0;
        mem_wr_en   = 1'b0;
        #1;
        check("rst_mid_ack", 64'(mem_ack_vld), 64'd0);
        check("rst_mid_cs", 64'(sram_cs), 64'd0);
        check("rst_mid_init_done", 64'(init_done), 64'd0);
        check("rst_mid_rdata", mem_rd_data, 64'd0);
        void'(sb_q.pop_back());
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (init_done) break;
        end
        check("reinit_done", 64'(init_done), 64'd1);
        issue("rd9_after_reinit", 32'd9, 1'b0, 1'b1, '0);
        wait_ack("rd9_after_reinit");
        release_req("rd9_after_reinit");

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
